vote_session_ctrl: RTL and testbench

VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

---
 rtl/vote_session_ctrl.sv | 169 ++++++++++++++++
 tb/tb_vote_session_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_session_ctrl.sv
// rtl/vote_session_ctrl.sv - single-session ballot counter with serial winner scan
//
// Purpose: opens a poll, accepts one ballot per vote_valid assertion, counts
// per-candidate tallies (saturating), then scans the tallies one candidate per
// cycle to produce winner flags (all ties flagged) and the winning count.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start, close        open the polls (IDLE/DONE) / close the polls (OPEN)
//   vote_valid,vote_sel ballot presented and its candidate index
//   vote_ready          ballot accept window
//   reject              one-cycle pulse for a refused ballot
//   rd_sel, rd_count    combinational tally read port
//   state               IDLE=0, OPEN=1, TALLY=2, DONE=3
//   win, win_num        winner flags (MSB = candidate 0) and winning count
//   result_valid        win/win_num are final

module vote_session_ctrl #(
   parameter int NCAND = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              close,
   input  logic              vote_valid,
   input  logic [2:0]        vote_sel,
   output logic              vote_ready,
   output logic              reject,
   input  logic [2:0]        rd_sel,
   output logic [31:0]       rd_count,
   output logic [1:0]        state,
   output logic [NCAND-1:0]  win,
   output logic [31:0]       win_num,
   output logic              result_valid
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OPEN  = 2'd1,
      S_TALLY = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] LAST = 3'(NCAND - 1);

   state_t                  state_q, state_d;
   logic [NCAND-1:0][31:0]  tally_q;
   logic                    arm_q;
   logic                    vv_q;
   logic                    reject_q;
   logic [2:0]              scan_q;
   logic [31:0]             max_q;
   logic [NCAND-1:0]        mask_q;
   logic [NCAND-1:0]        win_q;
   logic [31:0]             win_num_q;
   logic                    rv_q;

   logic                    sel_ok;
   logic                    handshake;
   logic                    accept;
   logic                    bad_sel;
   logic                    stray_rise;
   logic                    do_start;
   logic                    last_scan;
   logic [31:0]             cur;
   logic [NCAND-1:0]        onehot;
   logic [31:0]             max_d;
   logic [NCAND-1:0]        mask_d;

   assign sel_ok     = int'(vote_sel) < NCAND;
   assign handshake  = vote_valid & vote_ready;
   assign accept     = handshake & sel_ok;
   assign bad_sel    = handshake & ~sel_ok;
   // A ballot offered while the polls are not open is refused once, on its rising edge.
   assign stray_rise = vote_valid & ~vv_q & (state_q != S_OPEN);
   assign do_start   = start & ((state_q == S_IDLE) | (state_q == S_DONE));
   assign last_scan  = (scan_q == LAST);

   assign state        = state_q;
   assign reject       = reject_q;
   assign win          = win_q;
   assign win_num      = win_num_q;
   assign result_valid = rv_q;
   assign rd_count     = (int'(rd_sel) < NCAND) ? tally_q[rd_sel] : 32'd0;

   // One step of the winner scan. Candidate 0 maps to the MSB of the flags.
   always_comb begin
      cur    = (int'(scan_q) < NCAND) ? tally_q[scan_q] : 32'd0;
      onehot = {{(NCAND-1){1'b0}}, 1'b1} << (LAST - scan_q);
      max_d  = max_q;
      mask_d = mask_q;
      if (cur > max_q) begin
         max_d  = cur;
         mask_d = onehot;
      end else if (cur == max_q) begin
         mask_d = mask_q | onehot;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      vote_ready = (state_q == S_OPEN) & arm_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_OPEN;
         S_OPEN:  if (close) state_d = S_TALLY;
         S_TALLY: if (last_scan) state_d = S_DONE;
         S_DONE:  if (start) state_d = S_OPEN;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tally_q   <= '0;
         arm_q     <= 1'b0;
         vv_q      <= 1'b0;
         reject_q  <= 1'b0;
         scan_q    <= 3'd0;
         max_q     <= 32'd0;
         mask_q    <= '0;
         win_q     <= '0;
         win_num_q <= 32'd0;
         rv_q      <= 1'b0;
      end else begin
         vv_q     <= vote_valid;
         reject_q <= bad_sel | stray_rise;

         // Re-arm only after vote_valid is seen low, so a held ballot counts once.
         if (state_q != S_OPEN)        arm_q <= 1'b0;
         else if (handshake)           arm_q <= 1'b0;
         else if (!vote_valid)         arm_q <= 1'b1;

         if (do_start) begin
            tally_q   <= '0;
            win_q     <= '0;
            win_num_q <= 32'd0;
            rv_q      <= 1'b0;
         end

         if (state_q == S_OPEN) begin
            if (accept && tally_q[vote_sel] != 32'hFFFF_FFFF)
               tally_q[vote_sel] <= tally_q[vote_sel] + 32'd1;
            if (close) begin
               scan_q <= 3'd0;
               max_q  <= 32'd0;
               mask_q <= '0;
            end
         end

         if (state_q == S_TALLY) begin
            scan_q <= scan_q + 3'd1;
            max_q  <= max_d;
            mask_q <= mask_d;
            if (last_scan) begin
               scan_q    <= 3'd0;
               win_q     <= mask_d;
               win_num_q <= max_d;
               rv_q      <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb/tb_vote_session_ctrl.sv - self-checking bench for vote_session_ctrl
//
// Purpose: drives elections (directed and $urandom) and compares the DUT
// against a tally-array reference model.
// Ports: none (top-level bench).

module tb_vote_session_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        close;
   logic        vote_valid;
   logic [2:0]  vote_sel;
   logic        vote_ready;
   logic        reject;
   logic [2:0]  rd_sel;
   logic [31:0] rd_count;
   logic [1:0]  state;
   logic [4:0]  win;
   logic [31:0] win_num;
   logic        result_valid;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_tally [5];

   vote_session_ctrl #(.NCAND(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .close        (close),
      .vote_valid   (vote_valid),
      .vote_sel     (vote_sel),
      .vote_ready   (vote_ready),
      .reject       (reject),
      .rd_sel       (rd_sel),
      .rd_count     (rd_count),
      .state        (state),
      .win          (win),
      .win_num      (win_num),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_max();
      logic [31:0] mx = 32'd0;
      for (int i = 0; i < 5; i++) if (m_tally[i] > mx) mx = m_tally[i];
      return mx;
   endfunction

   function automatic logic [4:0] exp_win();
      logic [31:0] mx = exp_max();
      logic [4:0]  w  = 5'd0;
      for (int i = 0; i < 5; i++) if (m_tally[i] == mx) w[4-i] = 1'b1;
      return w;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 5; i++) m_tally[i] = 32'd0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      model_clear();
   endtask

   // One ballot: a low cycle to arm, then a single-cycle vote_valid pulse.
   task automatic cast(input logic [2:0] sel);
      vote_valid = 1'b0;
      tick();
      vote_sel   = sel;
      vote_valid = 1'b1;
      checks++;
      if (vote_ready !== 1'b1) begin
         failures++;
         $display("FAIL cast_ready sel=%0d got=%b exp=1", sel, vote_ready);
      end
      tick();
      checks++;
      if (reject !== (sel > 3'd4)) begin
         failures++;
         $display("FAIL cast_reject sel=%0d got=%b exp=%b", sel, reject, sel > 3'd4);
      end
      vote_valid = 1'b0;
      if (sel <= 3'd4 && m_tally[sel] != 32'hFFFF_FFFF) m_tally[sel] = m_tally[sel] + 32'd1;
   endtask

   // Returns number of edges from the close edge until result_valid (capped).
   task automatic do_close(output int n);
      close = 1'b1;
      tick();
      close = 1'b0;
      n = 0;
      while (result_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_clear();
      checks++;
      if ({state, vote_ready, reject, win, win_num, result_valid} !== 41'd0) begin
         failures++;
         $display("FAIL reset_outputs state=%0d ready=%b rej=%b win=%b num=%0d rv=%b exp=all0",
                  state, vote_ready, reject, win, win_num, result_valid);
      end
      for (int i = 0; i < 8; i++) begin
         rd_sel = 3'(i);
         #1;
         checks++;
         if (rd_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_tally sel=%0d got=%0d exp=0", i, rd_count);
         end
      end
   endtask

   task automatic test_stray_vote();
      vote_valid = 1'b1;
      vote_sel   = 3'd0;
      tick();
      checks++;
      if (reject !== 1'b1) begin
         failures++;
         $display("FAIL stray_reject got=%b exp=1", reject);
      end
      tick();
      checks++;
      if (reject !== 1'b0) begin
         failures++;
         $display("FAIL stray_reject_pulse got=%b exp=0", reject);
      end
      vote_valid = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int n;
      do_start();
      checks++;
      if (state !== 2'd1 || result_valid !== 1'b0 || win !== 5'd0) begin
         failures++;
         $display("FAIL basic_open state=%0d rv=%b win=%b exp=1/0/0", state, result_valid, win);
      end
      cast(3'd0); cast(3'd0); cast(3'd2); cast(3'd4); cast(3'd0);
      do_close(n);
      checks++;
      if (n !== 5) begin
         failures++;
         $display("FAIL basic_latency got=%0d exp=5", n);
      end
      checks++;
      if (win !== 5'b10000 || win_num !== 32'd3 || win !== exp_win()) begin
         failures++;
         $display("FAIL basic_result win=%b num=%0d exp=10000/3", win, win_num);
      end
      checks++;
      if (state !== 2'd3) begin
         failures++;
         $display("FAIL basic_done state=%0d exp=3", state);
      end
   endtask

   task automatic test_held();
      int n;
      do_start();
      vote_valid = 1'b0;
      tick();
      vote_sel   = 3'd1;
      vote_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (vote_ready !== 1'b0 || reject !== 1'b0) begin
            failures++;
            $display("FAIL held_cycle%0d ready=%b rej=%b exp=0/0", c, vote_ready, reject);
         end
      end
      vote_valid = 1'b0;
      m_tally[1] = 32'd1;
      rd_sel = 3'd1;
      #1;
      checks++;
      if (rd_count !== 32'd1) begin
         failures++;
         $display("FAIL held_count got=%0d exp=1", rd_count);
      end
      do_close(n);
   endtask

   task automatic test_tie_invalid();
      int n;
      do_start();
      cast(3'd1); cast(3'd3); cast(3'd6);
      do_close(n);
      checks++;
      if (win !== 5'b01010 || win_num !== 32'd1 || n !== 5) begin
         failures++;
         $display("FAIL tie_result win=%b num=%0d lat=%0d exp=01010/1/5", win, win_num, n);
      end
   endtask

   task automatic test_empty();
      int n;
      do_start();
      tick();
      do_close(n);
      checks++;
      if (win !== 5'b11111 || win_num !== 32'd0 || result_valid !== 1'b1) begin
         failures++;
         $display("FAIL empty_result win=%b num=%0d rv=%b exp=11111/0/1", win, win_num, result_valid);
      end
   endtask

   task automatic test_close_vote();
      int n;
      do_start();
      vote_valid = 1'b0;
      tick();
      vote_sel   = 3'd2;
      vote_valid = 1'b1;
      close      = 1'b1;
      start      = 1'b1;
      tick();
      vote_valid = 1'b0;
      close      = 1'b0;
      start      = 1'b0;
      m_tally[2] = 32'd1;
      checks++;
      if (state !== 2'd2) begin
         failures++;
         $display("FAIL close_priority state=%0d exp=2", state);
      end
      n = 0;
      while (result_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (win !== 5'b00100 || win_num !== 32'd1 || n !== 5) begin
         failures++;
         $display("FAIL close_vote win=%b num=%0d lat=%0d exp=00100/1/5", win, win_num, n);
      end
   endtask

   task automatic test_rst_tally();
      do_start();
      cast(3'd3); cast(3'd3);
      close = 1'b1;
      tick();
      close = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_clear();
      checks++;
      if ({state, vote_ready, reject, win, win_num, result_valid} !== 41'd0) begin
         failures++;
         $display("FAIL rst_tally state=%0d ready=%b rej=%b win=%b num=%0d rv=%b exp=all0",
                  state, vote_ready, reject, win, win_num, result_valid);
      end
      rd_sel = 3'd3;
      #1;
      checks++;
      if (rd_count !== 32'd0) begin
         failures++;
         $display("FAIL rst_tally_count got=%0d exp=0", rd_count);
      end
   endtask

   task automatic test_saturation();
      int n;
      do_start();
      dut.tally_q[0] = 32'hFFFF_FFFE;
      m_tally[0]     = 32'hFFFF_FFFE;
      cast(3'd0); cast(3'd0);
      rd_sel = 3'd0;
      #1;
      checks++;
      if (rd_count !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL sat_count got=%h exp=ffffffff", rd_count);
      end
      do_close(n);
      checks++;
      if (win !== exp_win() || win_num !== exp_max()) begin
         failures++;
         $display("FAIL sat_result win=%b num=%h exp=%b/%h", win, win_num, exp_win(), exp_max());
      end
   endtask

   task automatic test_random();
      int n;
      int nv;
      for (int e = 0; e < 8; e++) begin
         do_start();
         nv = $urandom_range(0, 14);
         for (int v = 0; v < nv; v++) cast(3'($urandom_range(0, 7)));
         do_close(n);
         checks++;
         if (n !== 5 || win !== exp_win() || win_num !== exp_max()) begin
            failures++;
            $display("FAIL rand%0d_result lat=%0d win=%b num=%0d exp=5/%b/%0d",
                     e, n, win, win_num, exp_win(), exp_max());
         end
         for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            #1;
            checks++;
            if (rd_count !== ((i < 5) ? m_tally[i] : 32'd0)) begin
               failures++;
               $display("FAIL rand%0d_tally sel=%0d got=%0d exp=%0d",
                        e, i, rd_count, (i < 5) ? m_tally[i] : 32'd0);
            end
         end
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      close      = 1'b0;
      vote_valid = 1'b0;
      vote_sel   = 3'd0;
      rd_sel     = 3'd0;
      model_clear();
      test_reset();
      test_stray_vote();
      test_basic();
      test_held();
      test_tie_invalid();
      test_empty();
      test_close_vote();
      test_rst_tally();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout exp=finish_before_2ms");
      $fatal(1);
   end

endmodule
